burst_read_arbiter: RTL and testbench
=====================================

# burst_read_arbiter

Round-robin arbiter that shares one `burst_read_pipeline` instance between `NUM_MASTERS` requesters. It accepts a burst request (address plus length-1) from one requester and forwards it to the pipeline's upstream port. It then routes every returned beat to that requester and releases the grant only after the last beat is consumed. Only one burst is outstanding at a time. A beat counter checks that the pipeline returns exactly length+1 beats.

## Interface
- `NUM_MASTERS`, 4: number of requesters, 2..8.
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width.
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `u_addr` in NUM_MASTERS*ADDR_WIDTH: request addresses, master i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `u_length` in NUM_MASTERS*8: burst length-1 per master, master i at [i*8 +: 8].
- `u_valid` in NUM_MASTERS: request valid per master.
- `u_ready` out NUM_MASTERS: request accepted, at most one bit high.
- `u_data` out DATA_WIDTH: returned data, broadcast to all masters.
- `u_rvalid` out NUM_MASTERS: beat valid, only the granted master's bit can be high.
- `u_last` out 1: last beat of burst, qualified by `u_rvalid`.
- `u_rready` in NUM_MASTERS: beat ready per master.
- `p_addr` out ADDR_WIDTH: address to pipeline `u_addr`.
- `p_length` out 8: length to pipeline `u_length`.
- `p_valid` out 1: to pipeline `u_valid`.
- `p_ready` in 1: from pipeline `u_ready`.
- `p_data` in DATA_WIDTH: from pipeline `d_data`.
- `p_rvalid` in 1: from pipeline `d_valid`.
- `p_last` in 1: from pipeline `d_last`.
- `p_rready` out 1: to pipeline `d_ready`.
- `busy` out 1: high in REQ or DATA.
- `gnt_id` out 3: index of the current or last granted master.
- `len_err` out 1: sticky error flag, cleared only by reset.

## Operation
- The FSM has three states: IDLE, REQ, DATA.
- **IDLE:**
  - Winner = first master with `u_valid` set, scanning upward from `rr_ptr` with wrap modulo NUM_MASTERS.
  - Drive `u_ready[winner]`=1 combinationally; the handshake is ready-on-valid.
  - Capture `u_addr[winner]` and `u_length[winner]`; set `gnt_id`<=winner; go to REQ.
  - With no valid request, stay in IDLE.
- **REQ:**
  - `p_valid`=1, `p_addr`/`p_length` = captured values.
  - When `p_valid && p_ready`: go to DATA, clear `beat_cnt` to 0.
- **DATA:**
  - `u_data`=`p_data`, `u_last`=`p_last`.
  - `u_rvalid[gnt_id]`=`p_rvalid`; all other bits 0.
  - `p_rready`=`u_rready[gnt_id]`.
  - Each beat handshake increments `beat_cnt`, 9 bits so that 256 beats fit.
  - On a beat handshake with `p_last`=1: `rr_ptr`<=(`gnt_id`+1) mod NUM_MASTERS; go to IDLE.
- **`p_rready` outside DATA:**
  - `p_rready`=1 in IDLE and REQ.
  - This is mandatory: the pipeline's `u_ready` is gated by its `d_ready`, so the pipeline cannot accept a request without it.
  - A `p_rvalid` beat outside DATA is dropped and sets `len_err`.
- **`len_err` conditions:**
  - A last beat arrives at count ≠ captured length+1.
  - `beat_cnt` would exceed length+1 without a last beat.
  - A stray beat arrives outside DATA.
- **Outputs outside their state:** `u_ready`=0 outside IDLE; `p_valid`=0 outside REQ; `u_rvalid`=0 outside DATA.
- **Reset (`rst_n` low at a clock edge):**
  - State IDLE, `rr_ptr`=0, `gnt_id`=0, `beat_cnt`=0, `len_err`=0.
  - Captured address and length = 0.
  - While `rst_n` is low, all combinational outputs are forced to their idle values: `u_ready`=0, `p_valid`=0, `u_rvalid`=0, `u_last`=0, `p_rready`=0, `busy`=0.
- **Reset mid-burst:** the burst is abandoned with no completion to the requester; the pipeline shares `rst_n` and is flushed with it.
- **Requests during a burst:** new `u_valid` during REQ/DATA waits; requesters must hold `u_valid` and payload stable until `u_ready`.

## Timing
- **Request path:** request accepted at cycle N (IDLE, `u_ready` pulse) → `p_valid`=1 from cycle N+1.
  - With a ready pipeline, the handshake completes at N+1 and the arbiter is in DATA at N+2.
- **Return path:** beat routing is combinational (zero latency); `p_rready` follows `u_rready[gnt_id]` in the same cycle.
- **Completion:** after the last-beat handshake at cycle M, the arbiter is in IDLE at M+1 and can accept the next request at M+1.
  - Minimum gap between bursts: 2 cycles of handshake overhead per burst.
- **`busy`** is registered state: high from N+1 through M, inclusive.
- **Fairness:** a continuously requesting master is granted within NUM_MASTERS bursts.

## Test plan
- **Single request, fully ready:** master 2 requests `u_addr`=0x100, `u_length`=3, `u_rready`=all 1.
  - `u_ready[2]` pulses once; `p_valid` for 1 cycle.
  - Exactly 4 beats with data 0x100..0x103 to master 2 only; `u_last` on the 4th.
  - `busy` low after; `len_err`=0.
- **All masters valid continuously**, lengths 0: grants in order 0,1,2,3,0,1,…; each master receives 1 beat with `u_last`=1.
- **Back-pressure:** master 1, length 7; `u_rready[1]` toggles 1/0 every cycle.
  - 8 beats delivered in order with no loss or duplication; `p_rready` mirrors `u_rready[1]`.
  - `u_rvalid[0,2,3]` never high.
- **Length 255:** 256 beats delivered; `beat_cnt` reaches 256 without `len_err`; no address wrap error for 0xFFFFFF00 start.
- **Reset mid-burst:** drop `rst_n` on beat 2 of a length-5 burst.
  - Next cycle: all outputs idle, `rr_ptr`=0.
  - A new request from master 3 is served normally after reset.
- **Protocol error:** model injects `p_last` on beat 2 of a length-3 burst → `len_err` goes high and stays high until reset; the FSM returns to IDLE.

Source files
------------

// File: rtl/burst_read_arbiter.sv
// burst_read_arbiter: round-robin sharing of one burst read pipeline among NUM_MASTERS requesters
module burst_read_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] u_addr,
    input  logic [NUM_MASTERS*8-1:0]          u_length,
    input  logic [NUM_MASTERS-1:0]            u_valid,
    output logic [NUM_MASTERS-1:0]            u_ready,
    output logic [DATA_WIDTH-1:0]             u_data,
    output logic [NUM_MASTERS-1:0]            u_rvalid,
    output logic                              u_last,
    input  logic [NUM_MASTERS-1:0]            u_rready,
    output logic [ADDR_WIDTH-1:0]             p_addr,
    output logic [7:0]                        p_length,
    output logic                              p_valid,
    input  logic                              p_ready,
    input  logic [DATA_WIDTH-1:0]             p_data,
    input  logic                              p_rvalid,
    input  logic                              p_last,
    output logic                              p_rready,
    output logic                              busy,
    output logic [2:0]                        gnt_id,
    output logic                              len_err
);
    localparam int IW = $clog2(NUM_MASTERS);
    typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;
    state_t state, state_nx;
    logic [IW-1:0] rr_ptr, winner, gid, idx;
    logic found, beat;
    logic [ADDR_WIDTH-1:0] addr_q, win_addr;
    logic [7:0] len_q, win_len;
    logic [8:0] beat_cnt, cnt_nx;
    assign gid = gnt_id[IW-1:0];
    assign u_data = p_data;
    assign beat = state == DATA && p_rvalid && u_rready[gid];
    assign cnt_nx = beat_cnt + 9'd1;
    always_comb begin
        found = 1'b0;
        winner = '0;
        idx = '0;
        win_addr = '0;
        win_len = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            idx = IW'((int'(rr_ptr) + k) % NUM_MASTERS);
            if (!found && u_valid[idx]) begin
                found = 1'b1;
                winner = idx;
            end
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (winner == IW'(i)) begin
                win_addr = u_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_len = u_length[i*8 +: 8];
            end
        end
    end
    // Every handshake output is held idle while reset is asserted.
    always_comb begin
        state_nx = state;
        u_ready = '0;
        u_rvalid = '0;
        u_last = 1'b0;
        p_valid = 1'b0;
        p_rready = 1'b0;
        busy = 1'b0;
        p_addr = addr_q;
        p_length = len_q;
        if (rst_n) begin
            busy = state != IDLE;
            p_rready = state == DATA ? u_rready[gid] : 1'b1;
            case (state)
                IDLE: begin
                    if (found) begin
                        u_ready[winner] = 1'b1;
                        state_nx = REQ;
                    end
                end
                REQ: begin
                    p_valid = 1'b1;
                    if (p_ready) state_nx = DATA;
                end
                DATA: begin
                    u_rvalid[gid] = p_rvalid;
                    u_last = p_last;
                    if (beat && p_last) state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            rr_ptr <= '0;
            gnt_id <= '0;
            beat_cnt <= '0;
            len_err <= 1'b0;
            addr_q <= '0;
            len_q <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && found) begin
                addr_q <= win_addr;
                len_q <= win_len;
                gnt_id <= 3'(winner);
            end
            if (state == REQ && p_ready) beat_cnt <= '0;
            if (beat && ~&beat_cnt) beat_cnt <= cnt_nx;
            if (beat && p_last) rr_ptr <= gid == IW'(NUM_MASTERS - 1) ? '0 : gid + IW'(1);
            // Early/late last beat, overlong burst, or a beat with no burst in flight.
            if ((beat && (p_last ? cnt_nx != {1'b0, len_q} + 9'd1 : cnt_nx > {1'b0, len_q} + 9'd1))
                || (state != DATA && p_rvalid))
                len_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_burst_read_arbiter.sv
// tb_burst_read_arbiter: table vectors, directed corner sequences and random traffic against a transaction-level model
module tb_burst_read_arbiter;
    localparam int N = 4, AW = 32, DW = 32;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [N*AW-1:0] u_addr;
    logic [N*8-1:0] u_length;
    logic [N-1:0] u_valid, u_ready, u_rvalid, u_rready;
    logic [DW-1:0] u_data, p_data;
    logic u_last, p_valid, p_ready, p_rvalid, p_last, p_rready, busy, len_err;
    logic [AW-1:0] p_addr;
    logic [7:0] p_length;
    logic [2:0] gnt_id;

    burst_read_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .u_addr(u_addr), .u_length(u_length), .u_valid(u_valid),
        .u_ready(u_ready), .u_data(u_data), .u_rvalid(u_rvalid), .u_last(u_last), .u_rready(u_rready),
        .p_addr(p_addr), .p_length(p_length), .p_valid(p_valid), .p_ready(p_ready), .p_data(p_data),
        .p_rvalid(p_rvalid), .p_last(p_last), .p_rready(p_rready), .busy(busy), .gnt_id(gnt_id),
        .len_err(len_err)
    );

    always #5 clk = ~clk;

    // requester model
    bit pend[N];
    logic [AW-1:0] raddr[N];
    logic [7:0] rlen[N];
    // transaction model: phase 0 = no burst, 1 = request to pipeline pending, 2 = beats flowing
    int phase, g, g_len, rcvd, model_rr;
    logic [AW-1:0] g_addr;
    bit exp_err;
    // pipeline model
    bit pb, stray;
    logic [AW-1:0] pa;
    int pl, ps, inj;
    // knobs and statistics
    int mode_rr, pct_pready, pct_rvalid;
    bit tog, auto_rereq;
    int completions, last_beats, last_gnt;
    int grants[$];
    int n_cmp, n_err;

    typedef struct {
        logic [3:0]    valid;
        logic [AW-1:0] addr;
        logic [7:0]    len;
        int            exp_g;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit rstv);
        int w, idx;
        bit last;
        @(negedge clk);
        rst_n = rstv;
        for (int m = 0; m < N; m++) begin
            u_valid[m] = pend[m];
            u_addr[m*AW +: AW] = raddr[m];
            u_length[m*8 +: 8] = rlen[m];
            u_rready[m] = mode_rr == 0 ? 1'b1 : mode_rr == 1 ? ($urandom_range(3) != 0) : tog;
        end
        tog = ~tog;
        p_ready = !pb && ($urandom_range(99) < pct_pready);
        p_rvalid = (pb && ($urandom_range(99) < pct_rvalid)) || stray;
        p_data = pb ? pa + ps : 32'hDEAD_BEEF;
        p_last = pb && (ps == pl || ps == inj);
        #1;
        if (!rst_n) begin
            chk("rst_u_ready", u_ready, 0);
            chk("rst_p_valid", p_valid, 0);
            chk("rst_u_rvalid", u_rvalid, 0);
            chk("rst_u_last", u_last, 0);
            chk("rst_p_rready", p_rready, 0);
            chk("rst_busy", busy, 0);
            phase = 0; model_rr = 0; exp_err = 0; pb = 0;
            for (int m = 0; m < N; m++) pend[m] = 0;
            return;
        end
        chk("busy", busy, phase != 0);
        chk("len_err", len_err, exp_err);
        chk("p_valid", p_valid, phase == 1);
        chk("p_rready", p_rready, phase == 2 ? u_rready[g] : 1'b1);
        chk("u_rvalid", u_rvalid, (phase == 2 && p_rvalid) ? (1 << g) : 0);
        if (phase != 0) chk("gnt_id", gnt_id, g);
        if (phase == 1) begin
            chk("p_addr", p_addr, g_addr);
            chk("p_length", p_length, g_len);
        end
        if (phase == 2 && p_rvalid) begin
            chk("u_data", u_data, g_addr + rcvd);
            chk("u_last", u_last, rcvd == g_len || rcvd == inj);
        end
        w = -1;
        if (phase == 0)
            for (int k = 0; k < N; k++) begin
                idx = (model_rr + k) % N;
                if (w < 0 && pend[idx]) w = idx;
            end
        chk("u_ready", u_ready, w < 0 ? 0 : (1 << w));
        if (phase != 2 && p_rvalid) exp_err = 1;
        if (phase == 0 && w >= 0) begin
            g = w; g_addr = raddr[w]; g_len = rlen[w]; pend[w] = 0; phase = 1;
            grants.push_back(w);
        end else if (phase == 1 && p_ready) begin
            pb = 1; pa = g_addr; pl = g_len; ps = 0; rcvd = 0; phase = 2;
        end else if (phase == 2 && p_rvalid && u_rready[g]) begin
            last = ps == pl || ps == inj;
            if (last && ps != pl) exp_err = 1;
            ps++; rcvd++;
            if (last) begin
                pb = 0; phase = 0; model_rr = (g + 1) % N;
                completions++; last_beats = rcvd; last_gnt = g;
                if (auto_rereq) pend[g] = 1;
            end
        end
    endtask

    task automatic run_done(input int budget);
        int c0 = completions;
        for (int n = 0; n < budget && completions == c0; n++) step(1);
        chk("burst_done", completions != c0, 1);
    endtask

    initial begin
        mode_rr = 0; pct_pready = 100; pct_rvalid = 100; inj = -1; stray = 0; tog = 0;
        for (int m = 0; m < N; m++) begin pend[m] = 0; raddr[m] = '0; rlen[m] = '0; end
        repeat (3) step(0);
        step(1);
        chk("rst_gnt_id", gnt_id, 0);
        chk("rst_len_err", len_err, 0);

        tbl[0] = '{4'b0100, 32'h0000_0100, 8'd3, 2};
        tbl[1] = '{4'b1111, 32'h0000_2000, 8'd0, 3};
        tbl[2] = '{4'b0110, 32'h0000_3000, 8'd1, 1};
        tbl[3] = '{4'b0011, 32'h0000_4000, 8'd2, 0};
        tbl[4] = '{4'b1001, 32'h0000_5000, 8'd0, 3};
        tbl[5] = '{4'b1000, 32'h0000_6000, 8'd4, 3};
        tbl[6] = '{4'b0001, 32'h0000_7000, 8'd0, 0};
        tbl[7] = '{4'b1110, 32'h0000_8000, 8'd1, 1};
        tbl[8] = '{4'b0111, 32'hFFFF_FF00, 8'd255, 2};
        tbl[9] = '{4'b0101, 32'h0000_9000, 8'd0, 0};
        for (int i = 0; i < 10; i++) begin
            for (int m = 0; m < N; m++) begin
                pend[m] = tbl[i].valid[m];
                raddr[m] = m == tbl[i].exp_g ? tbl[i].addr : tbl[i].addr + 32'(16 * (m + 1));
                rlen[m] = tbl[i].len;
            end
            run_done(600);
            for (int m = 0; m < N; m++) pend[m] = 0;
            chk("tbl_grant", last_gnt, tbl[i].exp_g);
            chk("tbl_beats", last_beats, tbl[i].len + 1);
        end
        step(1);
        chk("tbl_err_clear", len_err, 0);

        // all masters requesting back-to-back, single-beat bursts
        step(0);
        grants.delete();
        for (int m = 0; m < N; m++) begin pend[m] = 1; raddr[m] = 32'(m * 256); rlen[m] = 0; end
        auto_rereq = 1;
        for (int b = 0; b < 8; b++) begin
            run_done(50);
            chk("rr_beats", last_beats, 1);
        end
        auto_rereq = 0;
        for (int m = 0; m < N; m++) pend[m] = 0;
        chk("rr_count", grants.size(), 8);
        for (int k = 0; k < grants.size() && k < 8; k++) chk("rr_order", grants[k], k % N);

        // back-pressure from master 1
        mode_rr = 2;
        pend[1] = 1; raddr[1] = 32'h500; rlen[1] = 7;
        run_done(100);
        chk("bp_grant", last_gnt, 1);
        chk("bp_beats", last_beats, 8);
        mode_rr = 0;

        // reset in the middle of a burst
        pend[1] = 1; raddr[1] = 32'h580; rlen[1] = 0;
        run_done(20);
        pend[1] = 1; raddr[1] = 32'h600; rlen[1] = 5;
        for (int n = 0; n < 50 && !(phase == 2 && rcvd == 1); n++) step(1);
        chk("mid_reached", phase == 2 && rcvd == 1, 1);
        step(0);
        step(1);
        chk("mid_idle_busy", busy, 0);
        chk("mid_idle_rvalid", u_rvalid, 0);
        pend[1] = 1; raddr[1] = 32'h700; rlen[1] = 1;
        pend[3] = 1; raddr[3] = 32'h800; rlen[3] = 2;
        run_done(50);
        chk("mid_rr_reset", last_gnt, 1);
        run_done(50);
        chk("mid_m3_grant", last_gnt, 3);
        chk("mid_m3_beats", last_beats, 3);

        // early last beat from the pipeline
        pend[0] = 1; raddr[0] = 32'h900; rlen[0] = 3; inj = 1;
        run_done(50);
        inj = -1;
        step(1);
        chk("err_set", len_err, 1);
        chk("err_idle", busy, 0);
        chk("err_beats", last_beats, 2);
        pend[2] = 1; raddr[2] = 32'hA00; rlen[2] = 1;
        run_done(50);
        step(1);
        chk("err_sticky", len_err, 1);
        step(0);
        step(1);
        chk("err_cleared", len_err, 0);

        // stray beat while no burst is in flight
        stray = 1;
        step(1);
        stray = 0;
        step(1);
        chk("stray_err", len_err, 1);
        step(0);

        // random traffic
        begin
            int c0;
            mode_rr = 1; pct_pready = 60; pct_rvalid = 70;
            c0 = completions;
            for (int n = 0; n < 3000; n++) begin
                for (int m = 0; m < N; m++)
                    if (!pend[m] && !(phase != 0 && g == m) && $urandom_range(7) == 0) begin
                        pend[m] = 1; raddr[m] = $urandom; rlen[m] = 8'($urandom_range(15));
                    end
                step(1);
            end
            chk("rand_progress", completions > c0 + 20, 1);
            chk("rand_no_err", len_err, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
